// File: rtl/key_entry_pkg.sv
// Shared constants, key codes and FSM state type for the key_entry block.
package key_entry_pkg;

  localparam int KEY_W = 4;
  localparam int CNT_W = 3;
  localparam int BIN_W = 14;

  localparam logic [KEY_W-1:0] KEY_ENTER = 4'hC;
  localparam logic [KEY_W-1:0] KEY_BAD   = 4'hB;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_ACK     = 2'd2,
    ST_COMMIT  = 2'd3
  } state_e;

  function automatic logic is_digit(input logic [KEY_W-1:0] k);
    return (k <= 4'd9);
  endfunction

  function automatic int unsigned pow10(input int n);
    int unsigned r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

endpackage

// File: rtl/key_entry_if.sv
// Keyboard-decoder handshake and committed-value bus of key_entry.
// Carries value_bin only when KEY_ENTRY_BIN_EN is defined.
interface key_entry_if #(
  parameter int NUM_DIGITS = 4
) ();
  import key_entry_pkg::*;

  logic                    key_flag;
  logic [KEY_W-1:0]        key_char;
  logic                    clear_key;
  logic [4*NUM_DIGITS-1:0] value;
  logic                    value_valid;
  logic [CNT_W-1:0]        digit_count;
  logic                    entry_err;
`ifdef KEY_ENTRY_BIN_EN
  logic [BIN_W-1:0]        value_bin;

  modport master (
    output key_flag, key_char,
    input  clear_key, value, value_valid, digit_count, entry_err, value_bin
  );
  modport slave (
    input  key_flag, key_char,
    output clear_key, value, value_valid, digit_count, entry_err, value_bin
  );
`else
  modport master (
    output key_flag, key_char,
    input  clear_key, value, value_valid, digit_count, entry_err
  );
  modport slave (
    input  key_flag, key_char,
    output clear_key, value, value_valid, digit_count, entry_err
  );
`endif

endinterface

// File: rtl/key_sync.sv
// Multi-flop synchroniser for the asynchronous key_flag level.
module key_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic sync_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
  end

  assign sync_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/key_entry.sv
// BCD key-entry buffer: captures decoder keys, commits on Enter, flags bad keys.
// Optional KEY_ENTRY_BIN_EN adds value_bin, the binary form of value.
module key_entry
  import key_entry_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  key_entry_if.slave  bus
);

  localparam int VAL_W = 4 * NUM_DIGITS;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_W'(NUM_DIGITS)) ? c : c + 1'b1;
  endfunction

  logic             flag_sync;
  logic             flag_prev_q;
  state_e           state_q;
  logic [VAL_W-1:0] buf_q;
  logic [VAL_W-1:0] buf_d;
  logic [VAL_W-1:0] value_q;
  logic [CNT_W-1:0] count_q;
  logic             valid_q;
  logic             err_q;
  logic             clear_q;

  logic in_capture, key_is_digit, key_is_enter;
  logic cap_digit, cap_commit, cap_empty, cap_bad;

  key_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk     (clk),
    .rst     (rst),
    .async_i (bus.key_flag),
    .sync_o  (flag_sync)
  );

  // key_char is only looked at while in CAPTURE, after the flag has settled
  assign in_capture   = (state_q == ST_CAPTURE);
  assign key_is_digit = is_digit(bus.key_char);
  assign key_is_enter = (bus.key_char == KEY_ENTER);
  assign cap_digit    = in_capture && key_is_digit;
  assign cap_commit   = in_capture && key_is_enter && (count_q != '0);
  assign cap_empty    = in_capture && key_is_enter && (count_q == '0);
  assign cap_bad      = in_capture && !key_is_digit && !key_is_enter;

  // Truncating the concatenation drops the oldest digit once the buffer is full
  assign buf_d = VAL_W'({buf_q, bus.key_char});

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      flag_prev_q <= 1'b0;
      buf_q       <= '0;
      value_q     <= '0;
      count_q     <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      clear_q     <= 1'b0;
    end else begin
      flag_prev_q <= flag_sync;
      valid_q     <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (flag_sync && !flag_prev_q) state_q <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          if (cap_commit) begin
            value_q <= buf_q;
            valid_q <= 1'b1;
            buf_q   <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
            state_q <= ST_COMMIT;
          end else begin
            if (cap_digit) begin
              buf_q   <= buf_d;
              count_q <= sat_inc(count_q);
            end else if (cap_empty) begin
              err_q   <= 1'b1;
            end else if (cap_bad) begin
              buf_q   <= '0;
              count_q <= '0;
              err_q   <= 1'b1;
            end
            clear_q <= 1'b1;
            state_q <= ST_ACK;
          end
        end
        ST_COMMIT: begin
          clear_q <= 1'b1;
          state_q <= ST_ACK;
        end
        ST_ACK: begin
          // Leaving only on a low flag is what stops a held key retriggering
          if (!flag_sync) begin
            clear_q <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef KEY_ENTRY_BIN_EN
  localparam int unsigned TOP_WEIGHT = pow10(NUM_DIGITS - 1);

  logic [BIN_W-1:0] bin_acc_q;
  logic [BIN_W-1:0] bin_trim_d;
  logic [BIN_W-1:0] bin_acc_d;
  logic [BIN_W-1:0] value_bin_q;

  // Subtract the outgoing digit's weight so the accumulator tracks the buffer
  assign bin_trim_d = (count_q == CNT_W'(NUM_DIGITS))
                    ? bin_acc_q - BIN_W'(buf_q[VAL_W-1 -: 4]) * BIN_W'(TOP_WEIGHT)
                    : bin_acc_q;
  assign bin_acc_d  = bin_trim_d * BIN_W'(10) + BIN_W'(bus.key_char);

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_acc_q   <= '0;
      value_bin_q <= '0;
    end else if (cap_digit) begin
      bin_acc_q   <= bin_acc_d;
    end else if (cap_commit) begin
      value_bin_q <= bin_acc_q;
      bin_acc_q   <= '0;
    end else if (cap_bad) begin
      bin_acc_q   <= '0;
    end
  end

  assign bus.value_bin = value_bin_q;
`endif

  assign bus.clear_key   = clear_q;
  assign bus.value       = value_q;
  assign bus.value_valid = valid_q;
  assign bus.digit_count = count_q;
  assign bus.entry_err   = err_q;

endmodule

// File: tb/tb_key_entry.sv
// Self-checking bench for key_entry: directed scenarios plus random key streams
// checked against a digit-queue model of the entry buffer.
module tb_key_entry;
  import key_entry_pkg::*;

  localparam int NUM_DIGITS  = 4;
  localparam int SYNC_STAGES = 2;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  key_entry_if #(.NUM_DIGITS(NUM_DIGITS)) ke ();

  key_entry #(
    .NUM_DIGITS  (NUM_DIGITS),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (ke)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: digits held as a queue, oldest first
  int          m_q[$];
  logic [31:0] m_value;
  int          m_bin;
  logic        m_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_value = 0;
    m_bin   = 0;
    m_err   = 1'b0;
  endtask

  task automatic model_key(input int code, output int exp_pulses);
    int v, d;
    exp_pulses = 0;
    if (code <= 9) begin
      m_q.push_back(code);
      if (m_q.size() > NUM_DIGITS) void'(m_q.pop_front());
    end else if (code == 12) begin
      if (m_q.size() > 0) begin
        v = 0;
        d = 0;
        foreach (m_q[i]) begin
          v = v * 16 + m_q[i];
          d = d * 10 + m_q[i];
        end
        m_value    = v;
        m_bin      = d;
        m_err      = 1'b0;
        exp_pulses = 1;
        m_q.delete();
      end else begin
        m_err = 1'b1;
      end
    end else begin
      m_q.delete();
      m_err = 1'b1;
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_value"}, ke.value, m_value);
    check({tag, "_count"}, ke.digit_count, m_q.size());
    check({tag, "_err"}, ke.entry_err, m_err);
`ifdef KEY_ENTRY_BIN_EN
    check({tag, "_bin"}, ke.value_bin, m_bin);
`endif
  endtask

  // One full handshake: raise flag, wait for clear_key, drop flag, wait for release.
  task automatic press(input int code);
    int n, vv, lat, exp_p;
    @(negedge clk);
    ke.key_char = 4'(code);
    ke.key_flag = 1'b1;
    n = 0; vv = 0; lat = 0;
    while (ke.clear_key !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
      if (ke.value_valid === 1'b1) begin
        vv++;
        if (lat == 0) lat = n;
      end
    end
    check("ack_rise", ke.clear_key, 1);
    ke.key_flag = 1'b0;
    ke.key_char = 4'($urandom_range(0, 15));
    n = 0;
    while (ke.clear_key !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
      if (ke.value_valid === 1'b1) vv++;
    end
    check("ack_fall", ke.clear_key, 0);
    model_key(code, exp_p);
    check("pulses", vv, exp_p);
    // Flag set before edge 0: synchronised high after edge SYNC_STAGES-1, then CAPTURE, COMMIT
    if (exp_p == 1) check("latency", lat, SYNC_STAGES + 2);
    check_outputs("key");
  endtask

  // Flag kept high for 50 cycles after clear_key rises
  task automatic held_press(input int code);
    int n, cnt, vv, exp_p;
    @(negedge clk);
    ke.key_char = 4'(code);
    ke.key_flag = 1'b1;
    n = 0; vv = 0;
    while (ke.clear_key !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("held_ack_rise", ke.clear_key, 1);
    cnt = (ke.clear_key === 1'b1) ? 1 : 0;
    while (ke.clear_key === 1'b1 && cnt < 200) begin
      if (cnt == 50) ke.key_flag = 1'b0;
      @(negedge clk);
      if (ke.clear_key === 1'b1) cnt++;
      if (ke.value_valid === 1'b1) vv++;
    end
    ke.key_flag = 1'b0;
    check("held_clear_len", cnt, 50 + SYNC_STAGES);
    model_key(code, exp_p);
    check("held_pulses", vv, exp_p);
    check_outputs("held");
  endtask

  task automatic reset_in_ack(input int code);
    int n, spur;
    @(negedge clk);
    ke.key_char = 4'(code);
    ke.key_flag = 1'b1;
    n = 0;
    while (ke.clear_key !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("rst_ack_reached", ke.clear_key, 1);
    rst = 1'b1;
    @(negedge clk);
    model_reset();
    check("rst_clear_key", ke.clear_key, 0);
    check("rst_valid", ke.value_valid, 0);
    check_outputs("rst");
    rst = 1'b0;
    ke.key_flag = 1'b0;
    spur = 0;
    repeat (SYNC_STAGES + 8) begin
      @(negedge clk);
      if (ke.clear_key !== 1'b0 || ke.value_valid !== 1'b0 || ke.digit_count !== '0) spur++;
    end
    check("rst_no_spurious", spur, 0);
  endtask

  int codes_bad[5] = '{10, 11, 13, 14, 15};
  int r, code;

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    ke.key_flag = 1'b0;
    ke.key_char = 4'h0;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_clear_key", ke.clear_key, 0);
    check("reset_valid", ke.value_valid, 0);
    check_outputs("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 1,2,3,Enter
    press(1); press(2); press(3); press(12);
    check("seq123_value", ke.value, 32'h0123);
    // 1..5,Enter: oldest digit dropped
    press(1); press(2); press(3); press(4);
    check("sat_count4", ke.digit_count, 4);
    press(5);
    check("sat_count_hold", ke.digit_count, 4);
    press(12);
    check("seq12345_value", ke.value, 32'h2345);
    // 7,bad,9,Enter
    press(7); press(11);
    check("bad_err_set", ke.entry_err, 1);
    press(9); press(12);
    check("bad_then_value", ke.value, 32'h0009);
    check("bad_then_err", ke.entry_err, 0);
    // Enter on an empty buffer
    press(12);
    check("empty_enter_err", ke.entry_err, 1);
    check("empty_enter_value", ke.value, 32'h0009);

    held_press(6);
    press(12);

    press(4); press(8); press(12);
    reset_in_ack(3);
    press(5); press(12);
    check("post_rst_value", ke.value, 32'h0005);

    for (int k = 0; k < 120; k++) begin
      r = $urandom_range(0, 99);
      if (r < 60)      code = $urandom_range(0, 9);
      else if (r < 85) code = 12;
      else             code = codes_bad[$urandom_range(0, 4)];
      press(code);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    press(9); press(9); press(9); press(9); press(12);
    check("max_value", ke.value, 32'h9999);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_entry.md
KEY_ENTRY -- requirements
Module: key_entry

Interface
REQ-001 Parameter NUM_DIGITS, default 4, number of BCD digits held in the entry buffer (range 1..4).
REQ-002 Parameter SYNC_STAGES, default 2, flip-flop depth of the key_flag synchroniser (range 2..3).
REQ-003 clk  input  1  system clock; the only clock; all logic SHALL be on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 key_flag  input  1  "key ready" flag from the keyboard decoder, asynchronous to clk.
REQ-006 key_char  input  4  decoded key code: 0-9 digit, 0xC Enter, 0xB bad key.
REQ-007 clear_key  output  1  acknowledge to the keyboard decoder; requests that key_flag be dropped.
REQ-008 value  output  4*NUM_DIGITS  committed BCD value, most significant digit first.
REQ-009 value_valid  output  1  one-cycle pulse when value is updated.
REQ-010 digit_count  output  3  number of digits currently in the entry buffer.
REQ-011 entry_err  output  1  sticky error flag.

Function
REQ-012 key_flag SHALL pass through SYNC_STAGES flops before use; key_char SHALL be sampled only in CAPTURE, which is entered after the synchronised flag is seen high.
REQ-013 The FSM SHALL have states IDLE, CAPTURE, ACK and COMMIT.
REQ-014 IDLE->CAPTURE on a rising edge of the synchronised flag; a flag that is still high after ACK SHALL NOT retrigger.
REQ-015 CAPTURE (1 cycle): latch key_char and act on it; then ACK, or COMMIT for an Enter key with digit_count>0.
REQ-016 ACK: clear_key SHALL be 1; stay in ACK until the synchronised flag is 0, then clear_key SHALL be 0 and the FSM returns to IDLE.
REQ-017 Digit key: buffer <= {buffer[4*NUM_DIGITS-5:0], digit}; digit_count increments and saturates at NUM_DIGITS. On overflow the oldest digit is dropped.
REQ-018 Enter with digit_count>0: in COMMIT, value <= buffer, value_valid=1 for exactly that cycle, buffer and digit_count cleared, entry_err cleared; then ACK.
REQ-019 Enter with digit_count=0: no commit; entry_err is set.
REQ-020 Code 0xB, 0xA or 0xD-0xF: buffer and digit_count cleared, entry_err set; value unchanged.
REQ-021 Latency: from synchronised flag high to value_valid is exactly 2 clk cycles (CAPTURE, COMMIT).
REQ-022 value SHALL hold its last committed content until the next commit.

Reset
REQ-023 When rst=1 at a clock edge: FSM->IDLE; buffer, value, digit_count=0; value_valid, entry_err, clear_key=0; synchroniser flops=0.
REQ-024 Reset asserted in ACK SHALL drop clear_key on the next edge. A key_flag still high after reset SHALL be treated as a new key once its synchronised level is seen rising from 0.

Configuration
REQ-025 Macro KEY_ENTRY_BIN_EN: when defined, add output value_bin (14 bits), the binary equivalent of value, updated in the same cycle as value (accumulated as bin*10+digit per digit, reset to 0 with the buffer). When undefined, the port and its logic are absent and all other behaviour is identical.

Structure
REQ-026 Package key_entry_pkg SHALL hold the key-code constants (KEY_ENTER=0xC, KEY_BAD=0xB), the FSM state enum, and the width constants.
REQ-027 The synchroniser SHALL be a sub-module, key_sync, parameterised by SYNC_STAGES.

Verification
REQ-028 Keys 1,2,3,Enter -> value=0x0123, one value_valid pulse, digit_count back to 0, entry_err=0 (value_bin=123 if enabled).
REQ-029 Keys 1,2,3,4,5,Enter -> value=0x2345; digit_count stays at 4 after the 4th digit.
REQ-030 Keys 7, 0xB, 9, Enter -> entry_err=1 after 0xB, value=0x0009 and entry_err=0 after Enter.
REQ-031 key_flag held high 50 cycles -> clear_key held high 50+SYNC_STAGES cycles, only one key captured.
REQ-032 Enter with an empty buffer -> no value_valid, entry_err=1, value unchanged.
REQ-033 rst pulsed while in ACK with key_flag high -> clear_key=0 next cycle, all outputs at reset values, no spurious capture until key_flag toggles.
